// File: rtl/mod_inv_fermat.sv
// mod_inv_fermat: modular inverse inv = a^(Q-2) mod Q (Fermat) for Q = 12587009.
// A square-and-multiply FSM drives one pipelined Barrett multiplier (mul_mod).
// Optional build macro: MOD_INV_SELFCHECK_EN adds a final a*inv multiply and
// reports check_ok = (a*inv mod Q == 1) || (a == 0); otherwise check_ok is tied
// high once reset is released.

// Pipelined modular multiplier: o_p = i_x * i_y mod Q, valid MUL_LAT cycles
// after the operands are presented. MUL_LAT must be at least 3.
module mul_mod #(
  parameter int unsigned MUL_LAT = 10,
  parameter logic [23:0] Q       = 24'd12587009
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [23:0] i_x,
  input  logic [23:0] i_y,
  output logic [23:0] o_p
);

  localparam int unsigned W   = 24;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned MW  = 25;
  localparam int unsigned DLY = MUL_LAT - 2;

  // Barrett constant floor(2^48 / Q); fits in 25 bits because Q > 2^23.
  localparam logic [48:0]    MU_FULL = (49'd1 << 48) / {25'd0, Q};
  localparam logic [MW-1:0]  MU      = MU_FULL[MW-1:0];

  logic [PW-1:0] r_p1;
  logic [PW-1:0] r_p2;
  logic [MW-1:0] r_qh;
  logic [W-1:0]  r_dly [DLY];
  logic [25:0]   w_rem;
  logic [W-1:0]  w_red;

  // Remainder after the quotient estimate is < 2Q, so one conditional subtract.
  always_comb begin
    w_rem = 26'(r_p2) - 26'({24'd0, r_qh} * {25'd0, Q});
    w_red = (w_rem >= {2'd0, Q}) ? W'(w_rem - {2'd0, Q}) : w_rem[W-1:0];
  end

  // Stage 1 product, stage 2 quotient estimate, stage 3 reduction, then delay.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_qh <= '0;
      for (int unsigned k = 0; k < DLY; k++) r_dly[k] <= '0;
    end else begin
      r_p1     <= {24'd0, i_x} * {24'd0, i_y};
      r_p2     <= r_p1;
      r_qh     <= MW'(({25'd0, r_p1} * {48'd0, MU}) >> 48);
      r_dly[0] <= w_red;
      for (int unsigned k = 1; k < DLY; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  assign o_p = r_dly[DLY-1];

endmodule

module mod_inv_fermat #(
  parameter int unsigned MUL_LAT = 10,
  parameter logic [23:0] Q       = 24'd12587009
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [23:0] a,
  output logic        busy,
  output logic        done,
  output logic [23:0] inv,
  output logic        check_ok
);

  localparam int unsigned W     = 24;
  localparam int unsigned IW    = 5;
  localparam int unsigned CNT_W = $clog2(MUL_LAT);
  localparam logic [W-1:0] E    = Q - 24'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_WAIT_S,
    S_MUL,
    S_WAIT_M,
    S_CHK,
    S_WAIT_C
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_r;
  logic [W-1:0]     r_y;
  logic [IW-1:0]    r_i;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_inv;
  logic             r_check_ok;

  logic [W-1:0]     w_a_red;
  logic [W-1:0]     w_prod;

  // Operand reduction into [0, Q): 2^24 < 2Q so one subtract is enough.
  always_comb begin
    w_a_red = (a >= Q) ? W'(a - Q) : a;
  end

  // Multiplier operands come straight from r_r / r_y and stay put while waiting.
  mul_mod #(
    .MUL_LAT (MUL_LAT),
    .Q       (Q)
  ) u_mul (
    .clk    (clk),
    .resetn (resetn),
    .i_x    (r_r),
    .i_y    (r_y),
    .o_p    (w_prod)
  );

  // Square-and-multiply sequencer. Loading r and the first-square operands
  // happens on the accept edge (bit 23 of E), and the "next bit" decision is
  // folded into each capture cycle, so every op costs exactly MUL_LAT+1 cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_r        <= '0;
      r_y        <= '0;
      r_i        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inv      <= '0;
      r_check_ok <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifndef MOD_INV_SELFCHECK_EN
      r_check_ok <= 1'b1;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= w_a_red;
            r_r     <= w_a_red;
            r_y     <= w_a_red;
            r_i     <= IW'(22);
            r_busy  <= 1'b1;
            r_state <= S_SQR;
`ifdef MOD_INV_SELFCHECK_EN
            r_check_ok <= 1'b0;
`endif
          end
        end

        S_SQR: begin
          r_cnt   <= CNT_W'(MUL_LAT - 1);
          r_state <= S_WAIT_S;
        end

        S_MUL: begin
          r_cnt   <= CNT_W'(MUL_LAT - 1);
          r_state <= S_WAIT_M;
        end

        S_WAIT_S, S_WAIT_M: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if ((r_state == S_WAIT_S) && E[r_i]) begin
            r_r     <= w_prod;
            r_y     <= r_a;
            r_state <= S_MUL;
          end else if (r_i == '0) begin
`ifdef MOD_INV_SELFCHECK_EN
            r_r     <= w_prod;
            r_y     <= r_a;
            r_state <= S_CHK;
`else
            r_r     <= w_prod;
            r_inv   <= w_prod;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`endif
          end else begin
            r_r     <= w_prod;
            r_y     <= w_prod;
            r_i     <= r_i - IW'(1);
            r_state <= S_SQR;
          end
        end

`ifdef MOD_INV_SELFCHECK_EN
        S_CHK: begin
          r_cnt   <= CNT_W'(MUL_LAT - 1);
          r_state <= S_WAIT_C;
        end

        S_WAIT_C: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_inv      <= r_r;
            r_check_ok <= (w_prod == W'(1)) || (r_a == '0);
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
`endif

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign inv      = r_inv;
  assign check_ok = r_check_ok;

endmodule

// File: tb/tb_mod_inv_fermat.sv
// Bench for mod_inv_fermat: directed values, ignored/overlapping starts,
// mid-operation reset, and random operands against a square-and-multiply model.
`timescale 1ns/1ps
module tb_mod_inv_fermat;

  localparam logic [23:0] QV = 24'd12587009;
`ifdef MOD_INV_SELFCHECK_EN
  localparam int   LAT      = 408;
  localparam logic CHK_IDLE = 1'b0;
`else
  localparam int   LAT      = 397;
  localparam logic CHK_IDLE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [23:0] a = '0;
  logic        busy;
  logic        done;
  logic [23:0] inv;
  logic        check_ok;

  int total = 0;
  int bad   = 0;
  logic [23:0] sb_q [$];

  mod_inv_fermat dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .a        (a),
    .busy     (busy),
    .done     (done),
    .inv      (inv),
    .check_ok (check_ok)
  );

  always #5 clk = ~clk;

  // Reference: reduce a, then plain left-to-right exponentiation by Q-2.
  function automatic logic [23:0] model_inv(input logic [23:0] av);
    longint unsigned b, r, q;
    logic [23:0] e;
    q = longint'(QV);
    e = QV - 24'd2;
    b = longint'(av);
    if (b >= q) b = b - q;
    r = 1;
    for (int k = 23; k >= 0; k--) begin
      r = (r * r) % q;
      if (e[k]) r = (r * b) % q;
    end
    return 24'(r);
  endfunction

  // Pulse start for one cycle (that cycle is cycle 0); returns inside cycle 1.
  task automatic start_op(input logic [23:0] av);
    @(posedge clk); #1;
    start = 1'b1;
    a     = av;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 24'($urandom());
  endtask

  // Wait (bounded) for done; lat is the cycle index of done, -1 on timeout.
  task automatic wait_done(input int n0, output int lat, output int busy_lo);
    int n;
    lat = -1;
    busy_lo = 0;
    n = n0;
    while (n < 1000) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_lo++;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (inv !== 24'd0) begin bad++; $display("FAIL reset_inv got=%0d want=0", inv); end
    total++; if (check_ok !== 1'b0) begin bad++; $display("FAIL reset_check_ok got=%b want=0", check_ok); end
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (check_ok !== CHK_IDLE) begin bad++; $display("FAIL idle_check_ok got=%b want=%b", check_ok, CHK_IDLE); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_directed();
    logic [23:0] d_a [7];
    logic [23:0] d_e [7];
    logic [23:0] exp_v;
    int lat, blo;
    d_a = '{24'd1, 24'd2, 24'd3, 24'd12587008, 24'd0, 24'd12587009, 24'd12587011};
    d_e = '{24'd1, 24'd6293505, 24'd4195670, 24'd12587008, 24'd0, 24'd0, 24'd6293505};
    for (int k = 0; k < 7; k++) begin
      sb_q.push_back(d_e[k]);
      start_op(d_a[k]);
      wait_done(1, lat, blo);
      exp_v = sb_q.pop_front();
      total++; if (lat !== LAT) begin bad++; $display("FAIL dir_latency a=%0d got=%0d want=%0d", d_a[k], lat, LAT); end
      total++; if (blo !== 0) begin bad++; $display("FAIL dir_busy_window a=%0d low_cycles=%0d want=0", d_a[k], blo); end
      total++; if (inv !== exp_v) begin bad++; $display("FAIL dir_inv a=%0d got=%0d want=%0d", d_a[k], inv, exp_v); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL dir_busy_at_done a=%0d got=%b want=0", d_a[k], busy); end
      total++; if (check_ok !== 1'b1) begin bad++; $display("FAIL dir_check_ok a=%0d got=%b want=1", d_a[k], check_ok); end
      @(posedge clk);
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir_done_pulse a=%0d got=%b want=0", d_a[k], done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_v;
    int lat, blo;
    sb_q.push_back(24'd6293505);
    start_op(24'd2);
    repeat (99) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 24'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(101, lat, blo);
    exp_v = sb_q.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lat, LAT); end
    total++; if (inv !== exp_v) begin bad++; $display("FAIL ign_inv got=%0d want=%0d", inv, exp_v); end
    // Start in the done cycle: must be accepted.
    start = 1'b1;
    a     = 24'd3;
    sb_q.push_back(24'd4195670);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_rise got=%b want=1", busy); end
    @(posedge clk);
    wait_done(2, lat, blo);
    exp_v = sb_q.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
    total++; if (inv !== exp_v) begin bad++; $display("FAIL b2b_inv got=%0d want=%0d", inv, exp_v); end
    total++; if (blo !== 0) begin bad++; $display("FAIL b2b_busy_window low_cycles=%0d want=0", blo); end
  endtask

  task automatic test_reset_abort();
    logic [23:0] exp_v;
    int lat, blo, pulses, busy_hi;
    start_op(24'd5);
    repeat (199) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (inv !== 24'd0) begin bad++; $display("FAIL abort_inv got=%0d want=0", inv); end
    total++; if (check_ok !== 1'b0) begin bad++; $display("FAIL abort_check_ok got=%b want=0", check_ok); end
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    pulses  = 0;
    busy_hi = 0;
    repeat (450) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busy_hi++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_stray_done got=%0d want=0", pulses); end
    total++; if (busy_hi !== 0) begin bad++; $display("FAIL abort_stray_busy got=%0d want=0", busy_hi); end
    sb_q.push_back(24'd6293505);
    start_op(24'd2);
    wait_done(1, lat, blo);
    exp_v = sb_q.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL post_abort_latency got=%0d want=%0d", lat, LAT); end
    total++; if (inv !== exp_v) begin bad++; $display("FAIL post_abort_inv got=%0d want=%0d", inv, exp_v); end
  endtask

  task automatic test_random();
    logic [23:0] av, exp_v;
    int lat, blo;
    for (int k = 0; k < 16; k++) begin
      av = (k == 0) ? 24'hFFFFFF : 24'($urandom());
      sb_q.push_back(model_inv(av));
      start_op(av);
      wait_done(1, lat, blo);
      exp_v = sb_q.pop_front();
      total++; if (inv !== exp_v) begin bad++; $display("FAIL rnd_inv a=%0d got=%0d want=%0d", av, inv, exp_v); end
      total++; if (lat !== LAT) begin bad++; $display("FAIL rnd_latency a=%0d got=%0d want=%0d", av, lat, LAT); end
      total++; if (check_ok !== 1'b1) begin bad++; $display("FAIL rnd_check_ok a=%0d got=%b want=1", av, check_ok); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_inv_fermat.md
Name: mod_inv_fermat

Overview:
- Computes the modular inverse inv = a^(q-2) mod q for q = 12587009 (0xC01001), using Fermat's little theorem. This is the inverse-direction companion of the team's Barrett modular multiplier.
- Feeds a single pipelined modular multiplier instance (mul_mod, 10-cycle latency) from a square-and-multiply FSM.
- Used by the NTT control path to produce the inverse scaling constants n^-1 and twiddle inverses.
- Exposes a start/busy/done handshake; one inversion at a time.

Parameters:
- MUL_LAT, 10, cycles from operand presentation at the multiplier inputs to a valid product at its output. Must match the instantiated mul_mod.
- Q, 24'd12587009, modulus. Exponent E = Q-2 = 24'hC00FFF is a localparam derived from it.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  request a new inversion; sampled only while busy=0
- a  in  24  operand, captured on the accepted start cycle; may be any value 0..2^24-1
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses
- done  out  1  single-cycle pulse, inv is valid from this cycle
- inv  out  24  result, always < Q; held until the next accepted start
- check_ok  out  1  self-check flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, inv=0, check_ok=0, bit counter=0. Reset asserted mid-operation aborts immediately, with no done pulse.
- Stale products still in the multiplier pipeline after reset are never captured. Capture happens only at issue+MUL_LAT of an op issued after reset.
- Operand capture: on an accepted start, a_r <= (a >= Q) ? a - Q : a. One subtract suffices because 2^24 < 2Q.
- States:
  - IDLE: on start, go to LOAD.
  - LOAD: r <= a_r, bit index i <= 22, go to SQR.
  - SQR: issue r*r.
  - WAIT_S: count MUL_LAT cycles, then capture r. If E[i]=1, go to MUL; else go to NEXT.
  - MUL: issue r*a_r.
  - WAIT_M: count MUL_LAT cycles, capture r, go to NEXT.
  - NEXT: if i==0, go to DONE; else i <= i-1 and go to SQR. NEXT is folded into the capture cycle and costs no extra cycle.
  - DONE: inv <= r, done=1, busy=0, go to IDLE.
- Op timing: each multiply occupies exactly MUL_LAT+1 cycles (issue, then capture MUL_LAT cycles later). The next issue is on the following cycle.
- Op count: E has bit 23 set (consumed by LOAD), 23 squarings and 13 conditional multiplies, 36 ops in total.
- Latency, start cycle = 0: done is high in cycle 36*(MUL_LAT+1)+1 = 397 for MUL_LAT=10. This is fixed and independent of a.
- Multiplier operands are driven from registers only. Operands are held stable for the whole issue-to-capture window.
- start while busy=1 is ignored, with no effect on a_r or the result.
- start in the same cycle as done is accepted: done pulses, and busy rises next cycle.
- a_r=0 runs the full sequence and yields inv=0. No error flag is raised.
- done and the next start never overlap within one op. No back-to-back throughput is required.

Optional Feature:
- Macro: MOD_INV_SELFCHECK_EN.
- When defined:
  - After the last op, one extra op a_r*r is issued (state CHK).
  - done is delayed by MUL_LAT+1 cycles (408 for MUL_LAT=10).
  - check_ok = (product == 1) || (a_r == 0), updated with done and held until the next start; it clears to 0 at accepted start.
- When undefined:
  - No CHK state; latency is 397.
  - check_ok is tied to 1 after reset release (0 during reset).

Test Plan:
- a=1 -> done at cycle 397, inv=1, busy high cycles 1..396.
- a=2 -> inv=6293505; a=3 -> inv=4195670 (3*4195670 mod Q = 1).
- a=12587008 (Q-1) -> inv=12587008; a=0 -> inv=0; a=12587009 (=Q, reduced to 0) -> inv=0; a=12587011 (=Q+2) -> inv=6293505.
- Start a=2, pulse start with a=3 at cycle 100 -> ignored, inv=6293505 at 397; start a=3 in the done cycle -> accepted, next done 397 cycles later with 4195670.
- Start a=5, deassert resetn at cycle 200 for 3 cycles -> busy/done/inv=0 immediately, no done pulse afterwards. Then start a=2 -> inv=6293505 at the correct cycle.
- With MOD_INV_SELFCHECK_EN: random a over 1000 inversions vs. software pow(a,Q-2,Q) -> all match, check_ok=1, done at cycle 408. Without the macro the same run completes at 397.
